// File: rtl/logic_gates_pkg.sv
// -----------------------------------------------------------------------------
// logic_gates_pkg
// Shared definitions for the registered primitive-logic unit.
//   DEFAULT_WIDTH  : default operand/result width (1)
//   MAX_WIDTH      : widest supported operand (64)
//   gate_bit_t     : the seven gate outputs for one bit position
//   gate_results_t : the seven results at full supported width, for consumers
//                    that want to pass a whole result set around as one value
// Field order everywhere is and, not, or, xor, xnor, nand, nor.
// -----------------------------------------------------------------------------
package logic_gates_pkg;

  localparam int DEFAULT_WIDTH = 1;
  localparam int MAX_WIDTH     = 64;

  // One bit position of every gate.
  typedef struct packed {
    logic and_g;
    logic not_g;
    logic or_g;
    logic xor_g;
    logic xnor_g;
    logic nand_g;
    logic nor_g;
  } gate_bit_t;

  // Full result set; a WIDTH-bit instance uses bits [WIDTH-1:0] of each field.
  typedef struct packed {
    logic [MAX_WIDTH-1:0] and_r;
    logic [MAX_WIDTH-1:0] not_r;
    logic [MAX_WIDTH-1:0] or_r;
    logic [MAX_WIDTH-1:0] xor_r;
    logic [MAX_WIDTH-1:0] xnor_r;
    logic [MAX_WIDTH-1:0] nand_r;
    logic [MAX_WIDTH-1:0] nor_r;
  } gate_results_t;

endpackage : logic_gates_pkg

// File: rtl/logic_gates_gate_cell.sv
// -----------------------------------------------------------------------------
// gate_cell
// Purely combinational single-bit slice: all seven primitive gates of i_a/i_b.
//   i_a, i_b : operand bits
//   o_and .. o_nor : gate outputs (o_not depends on i_a only)
// -----------------------------------------------------------------------------
module gate_cell (
  input  logic i_a,
  input  logic i_b,
  output logic o_and,
  output logic o_not,
  output logic o_or,
  output logic o_xor,
  output logic o_xnor,
  output logic o_nand,
  output logic o_nor
);

  assign o_and  = i_a & i_b;
  assign o_not  = ~i_a;
  assign o_or   = i_a | i_b;
  assign o_xor  = i_a ^ i_b;
  // Complement forms are derived from the base gates so the xnor/nand/nor
  // identities hold structurally, including for X operands.
  assign o_xnor = ~o_xor;
  assign o_nand = ~o_and;
  assign o_nor  = ~o_or;

endmodule : gate_cell

// File: rtl/logic_gates.sv
// -----------------------------------------------------------------------------
// logic_gates
// Registered two-operand bitwise logic unit, one-cycle latency, one operand
// pair per cycle.
//   clk, rst         : clock, asynchronous active-high reset
//   in_valid, a, b   : operands, captured when in_valid is high
//   and_o .. nor_o   : registered gate results, held while in_valid is low
//   out_valid        : results were loaded on the previous edge
// -----------------------------------------------------------------------------
module logic_gates
  import logic_gates_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] and_o,
  output logic [WIDTH-1:0] not_o,
  output logic [WIDTH-1:0] or_o,
  output logic [WIDTH-1:0] xor_o,
  output logic [WIDTH-1:0] xnor_o,
  output logic [WIDTH-1:0] nand_o,
  output logic [WIDTH-1:0] nor_o,
  output logic             out_valid
);

  gate_bit_t [WIDTH-1:0] w_gates;
  gate_bit_t [WIDTH-1:0] r_gates;
  logic                  r_out_valid;

  // One gate slice per bit; no bit depends on any other.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    gate_cell u_cell (
      .i_a    (a[i]),
      .i_b    (b[i]),
      .o_and  (w_gates[i].and_g),
      .o_not  (w_gates[i].not_g),
      .o_or   (w_gates[i].or_g),
      .o_xor  (w_gates[i].xor_g),
      .o_xnor (w_gates[i].xnor_g),
      .o_nand (w_gates[i].nand_g),
      .o_nor  (w_gates[i].nor_g)
    );
  end

  // Reset clears every result to 0, including the inverting gates, so nothing
  // but zeros leaves the block while rst is high.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gates     <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_gates <= w_gates;
      end
    end
  end

  // Unpack the per-bit register bank into the per-gate output vectors.
  // NOTE: every always_comb output gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    and_o  = '0;
    not_o  = '0;
    or_o   = '0;
    xor_o  = '0;
    xnor_o = '0;
    nand_o = '0;
    nor_o  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      and_o[i]  = r_gates[i].and_g;
      not_o[i]  = r_gates[i].not_g;
      or_o[i]   = r_gates[i].or_g;
      xor_o[i]  = r_gates[i].xor_g;
      xnor_o[i] = r_gates[i].xnor_g;
      nand_o[i] = r_gates[i].nand_g;
      nor_o[i]  = r_gates[i].nor_g;
    end
  end

  assign out_valid = r_out_valid;

endmodule : logic_gates

// File: tb/tb_logic_gates.sv
// -----------------------------------------------------------------------------
// tb_logic_gates
// Drives a WIDTH=1 and a WIDTH=8 instance with shared clk/rst/in_valid.
// The driver pushes expected results into per-instance queues; a monitor on
// the falling edge pops and compares whenever out_valid is high, and checks
// the held values and complement identities otherwise.
// Expected values come from directed constants or from a truth-table model.
// -----------------------------------------------------------------------------
module tb_logic_gates;

  typedef struct packed {
    logic [7:0] and_v;
    logic [7:0] not_v;
    logic [7:0] or_v;
    logic [7:0] xor_v;
    logic [7:0] xnor_v;
    logic [7:0] nand_v;
    logic [7:0] nor_v;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] a8, b8;
  logic       a1, b1;
  logic [7:0] and8, not8, or8, xor8, xnor8, nand8, nor8;
  logic       and1, not1, or1, xor1, xnor1, nand1, nor1;
  logic       ov8, ov1;

  int   n_vec = 0;
  int   n_bad = 0;
  exp_t q8[$];
  exp_t q1[$];
  exp_t last8, last1;
  bit   loaded8, loaded1;

  // Truth table indexed by {a,b}; bits are {and,not,or,xor,xnor,nand,nor}.
  logic [6:0] tt [4];

  logic_gates #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a8), .b(b8),
    .and_o(and8), .not_o(not8), .or_o(or8), .xor_o(xor8), .xnor_o(xnor8),
    .nand_o(nand8), .nor_o(nor8), .out_valid(ov8)
  );

  logic_gates #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a1), .b(b1),
    .and_o(and1), .not_o(not1), .or_o(or1), .xor_o(xor1), .xnor_o(xnor1),
    .nand_o(nand1), .nor_o(nor1), .out_valid(ov1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Replicate one truth-table row across w bits.
  function automatic exp_t rep(input logic [6:0] r, input int w);
    exp_t       e;
    logic [7:0] m;
    m = 8'((16'h1 << w) - 1);
    e.and_v  = {8{r[6]}} & m;
    e.not_v  = {8{r[5]}} & m;
    e.or_v   = {8{r[4]}} & m;
    e.xor_v  = {8{r[3]}} & m;
    e.xnor_v = {8{r[2]}} & m;
    e.nand_v = {8{r[1]}} & m;
    e.nor_v  = {8{r[0]}} & m;
    return e;
  endfunction

  // Reference model: per-bit truth-table lookup.
  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input int w);
    exp_t       e;
    logic [6:0] r;
    e = '0;
    for (int i = 0; i < w; i++) begin
      r = tt[{a[i], b[i]}];
      e.and_v[i]  = r[6];
      e.not_v[i]  = r[5];
      e.or_v[i]   = r[4];
      e.xor_v[i]  = r[3];
      e.xnor_v[i] = r[2];
      e.nand_v[i] = r[1];
      e.nor_v[i]  = r[0];
    end
    return e;
  endfunction

  task automatic check8(input string tag, input exp_t e);
    cmp({tag, "8_and"},  and8,  e.and_v);
    cmp({tag, "8_not"},  not8,  e.not_v);
    cmp({tag, "8_or"},   or8,   e.or_v);
    cmp({tag, "8_xor"},  xor8,  e.xor_v);
    cmp({tag, "8_xnor"}, xnor8, e.xnor_v);
    cmp({tag, "8_nand"}, nand8, e.nand_v);
    cmp({tag, "8_nor"},  nor8,  e.nor_v);
  endtask

  task automatic check1(input string tag, input exp_t e);
    cmp({tag, "1_and"},  {7'b0, and1},  e.and_v);
    cmp({tag, "1_not"},  {7'b0, not1},  e.not_v);
    cmp({tag, "1_or"},   {7'b0, or1},   e.or_v);
    cmp({tag, "1_xor"},  {7'b0, xor1},  e.xor_v);
    cmp({tag, "1_xnor"}, {7'b0, xnor1}, e.xnor_v);
    cmp({tag, "1_nand"}, {7'b0, nand1}, e.nand_v);
    cmp({tag, "1_nor"},  {7'b0, nor1},  e.nor_v);
  endtask

  task automatic check_zero(input string tag);
    check8(tag, '0);
    check1(tag, '0);
    cmp({tag, "_ov8"}, {7'b0, ov8}, 8'h00);
    cmp({tag, "_ov1"}, {7'b0, ov1}, 8'h00);
  endtask

  // Monitor: falling edge, away from the capture edge.
  always @(negedge clk) begin
    if (rst) begin
      check_zero("rst_hold");
      last8   = '0;
      last1   = '0;
      loaded8 = 1'b0;
      loaded1 = 1'b0;
    end else begin
      if (ov8) begin
        if (q8.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL unexpected_ov8: got out_valid=1 expected no result at %0t", $time);
        end else begin
          last8 = q8.pop_front();
          loaded8 = 1'b1;
          check8("res", last8);
        end
      end else begin
        check8("hold", last8);
      end
      if (ov1) begin
        if (q1.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL unexpected_ov1: got out_valid=1 expected no result at %0t", $time);
        end else begin
          last1 = q1.pop_front();
          loaded1 = 1'b1;
          check1("res", last1);
        end
      end else begin
        check1("hold", last1);
      end
      if (loaded8) begin
        cmp("id8_xnor", xnor8, ~xor8);
        cmp("id8_nand", nand8, ~and8);
        cmp("id8_nor",  nor8,  ~or8);
      end
      if (loaded1) begin
        cmp("id1_xnor", {7'b0, xnor1}, {7'b0, ~xor1});
        cmp("id1_nand", {7'b0, nand1}, {7'b0, ~and1});
        cmp("id1_nor",  {7'b0, nor1},  {7'b0, ~or1});
      end
    end
  end

  // Present one cycle of stimulus just after the rising edge; the capture
  // happens on the next rising edge, so expectations are queued now.
  task automatic drive(input logic v, input logic [7:0] av, input logic [7:0] bv,
                       input logic a1v, input logic b1v,
                       input exp_t e8, input exp_t e1);
    @(posedge clk);
    #1;
    in_valid = v;
    a8 = av;  b8 = bv;
    a1 = a1v; b1 = b1v;
    if (v && !rst) begin
      q8.push_back(e8);
      q1.push_back(e1);
    end
  endtask

  task automatic drive_rand(input logic v);
    logic [7:0] av, bv;
    av = 8'($urandom);
    bv = 8'($urandom);
    drive(v, av, bv, av[0], bv[0], model(av, bv, 8), model(av, bv, 1));
  endtask

  logic [6:0] row_exp [4];
  logic [3:0] ab_seq;

  initial begin
    tt[0] = 7'b0100111;  // 00
    tt[1] = 7'b0111010;  // 01
    tt[2] = 7'b0011010;  // 10
    tt[3] = 7'b1010100;  // 11
    row_exp[0] = 7'b0100111;
    row_exp[1] = 7'b0111010;
    row_exp[2] = 7'b0011010;
    row_exp[3] = 7'b1010100;

    last8 = '0; last1 = '0; loaded8 = 1'b0; loaded1 = 1'b0;
    in_valid = 1'b0;
    a8 = 8'hFF; b8 = 8'hFF; a1 = 1'b1; b1 = 1'b1;

    // Reset asserted between edges before any clock activity.
    rst = 1'b0;
    #2 rst = 1'b1;
    #1 check_zero("rst_async0");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Truth table on both widths (8-bit instance sees replicated bits).
    for (int k = 0; k < 4; k++) begin
      ab_seq = 4'(k);
      drive(1'b1, {8{ab_seq[1]}}, {8{ab_seq[0]}}, ab_seq[1], ab_seq[0],
            rep(row_exp[k], 8), rep(row_exp[k], 1));
    end

    // Hold: load 1/1 then three idle cycles with zero operands.
    drive(1'b1, 8'hFF, 8'hFF, 1'b1, 1'b1, rep(7'b1010100, 8), rep(7'b1010100, 1));
    repeat (3) drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, '0, '0);

    // Directed 8-bit vector; the 1-bit instance sees bit 0 (a=0,b=0).
    drive(1'b1, 8'hF0, 8'hAA, 1'b0, 1'b0,
          '{and_v: 8'hA0, not_v: 8'h0F, or_v: 8'hFA, xor_v: 8'h5A,
            xnor_v: 8'hA5, nand_v: 8'h5F, nor_v: 8'h05},
          rep(7'b0100111, 1));
    repeat (2) drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, '0, '0);

    // Asynchronous reset mid-cycle with non-zero results present, then a
    // capture attempted while reset is held.
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_zero("rst_async1");
    drive(1'b1, 8'hFF, 8'hFF, 1'b1, 1'b1, '0, '0);
    drive(1'b1, 8'hFF, 8'hFF, 1'b1, 1'b1, '0, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    drive(1'b1, 8'hFF, 8'hFF, 1'b1, 1'b1, rep(7'b1010100, 8), rep(7'b1010100, 1));

    // Back-to-back random traffic, then random traffic with idle gaps.
    for (int n = 0; n < 1000; n++) drive_rand(1'b1);
    for (int n = 0; n < 200; n++) drive_rand(1'($urandom_range(0, 1)));
    repeat (3) drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, '0, '0);
    @(negedge clk);

    cmp("q8_drained", 8'(q8.size()), 8'h00);
    cmp("q1_drained", 8'(q1.size()), 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_logic_gates
